// File: rtl/mips_prog_loader.sv
// mips_prog_loader: framed big-endian byte-stream boot loader for the MIPS core's instruction memory.
// Define MIPS_LOADER_CHECKSUM_EN to require a trailing byte that zeroes the mod-256 payload sum.
module mips_prog_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);
   typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CHK, FLUSH, DONE, ERR} state_t;
`ifdef MIPS_LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   localparam state_t AFTER_DATA = CHK_EN ? CHK : FLUSH;
   localparam logic [32:0] LIMIT = 33'd1 << ADDR_W;
   state_t state;
   logic [15:0] n;
   logic [23:0] shreg;
   logic [1:0] byte_cnt;
`ifdef MIPS_LOADER_CHECKSUM_EN
   logic [7:0] sum;
`endif
   logic take, last_word;
   logic [15:0] hdr_n;
   logic [32:0] hdr_end;
   assign take = in_valid && in_ready;
   assign hdr_n = {n[15:8], in_data};
   assign hdr_end = 33'(BASE_ADDR) + 33'(hdr_n);
   assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, n};
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state <= HDR_HI;
         in_ready <= 1'b1;
         cpu_hold <= 1'b1;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         done <= 1'b0;
         err <= 1'b0;
         words_loaded <= '0;
         n <= '0;
         shreg <= '0;
         byte_cnt <= '0;
`ifdef MIPS_LOADER_CHECKSUM_EN
         sum <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         case (state)
            HDR_HI: if (take) begin
               n[15:8] <= in_data;
               state <= HDR_LO;
            end
            HDR_LO: if (take) begin
               n[7:0] <= in_data;
               if (hdr_n == 16'd0) begin
                  state <= AFTER_DATA;
                  in_ready <= CHK_EN;
               end else if (hdr_end > LIMIT) begin
                  state <= ERR;
                  in_ready <= 1'b0;
                  err <= 1'b1;
               end else
                  state <= DATA;
            end
            DATA: if (take) begin
               shreg <= {shreg[15:0], in_data};
               byte_cnt <= byte_cnt + 2'd1;
`ifdef MIPS_LOADER_CHECKSUM_EN
               sum <= sum + in_data;
`endif
               if (byte_cnt == 2'd3) begin
                  mem_we <= 1'b1;
                  mem_addr <= ADDR_W'(BASE_ADDR) + words_loaded[ADDR_W-1:0];
                  mem_wdata <= {shreg, in_data};
                  words_loaded <= words_loaded + (ADDR_W+1)'(1);
                  if (last_word) begin
                     state <= AFTER_DATA;
                     in_ready <= CHK_EN;
                  end
               end
            end
`ifdef MIPS_LOADER_CHECKSUM_EN
            CHK: if (take) begin
               in_ready <= 1'b0;
               if (sum + in_data == 8'd0)
                  state <= FLUSH;
               else begin
                  state <= ERR;
                  err <= 1'b1;
               end
            end
`endif
            // FLUSH lets the final write strobe retire before the core is released
            FLUSH: begin
               state <= DONE;
               done <= 1'b1;
               cpu_hold <= 1'b0;
            end
            DONE, ERR: if (start) begin
               state <= HDR_HI;
               in_ready <= 1'b1;
               cpu_hold <= 1'b1;
               done <= 1'b0;
               err <= 1'b0;
               words_loaded <= '0;
               byte_cnt <= '0;
`ifdef MIPS_LOADER_CHECKSUM_EN
               sum <= '0;
`endif
            end
            default: state <= ERR;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: directed checks of the boot loader's framing, writes, errors and reset.
module tb_mips_prog_loader;
   logic clk1 = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic in_ready, mem_we, cpu_hold, done, err;
   logic [9:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [10:0] words_loaded;
   int errors = 0, checks = 0, nw = 0, w0 = 0;
   logic [9:0] wa [64];
   logic [31:0] wd [64];
   logic [10:0] wl [64];
   logic [7:0] fr [$];

   mips_prog_loader dut (
      .clk1(clk1), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
   );

   always #5 clk1 = ~clk1;

   always @(posedge clk1) if (mem_we && nw < 64) begin
      wa[nw] = mem_addr;
      wd[nw] = mem_wdata;
      wl[nw] = words_loaded;
      nw++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      in_valid = 1'b1;
      in_data = b;
      while (!in_ready && t < 20) begin
         @(negedge clk1);
         t++;
      end
      chk("byte_accept", {31'd0, in_ready}, 32'd1);
      @(negedge clk1);
      in_valid = 1'b0;
   endtask

   task automatic send_all();
      foreach (fr[i]) send(fr[i]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk1);
      start = 1'b0;
   endtask

   task automatic finish_frame();
      chk("flush_done", {31'd0, done}, 32'd0);
      chk("flush_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk1);
      chk("done", {31'd0, done}, 32'd1);
      chk("cpu_release", {31'd0, cpu_hold}, 32'd0);
   endtask

   task automatic chk_write(input int i, input logic [9:0] a, input logic [31:0] d);
      chk("wr_addr", {22'd0, wa[w0+i]}, {22'd0, a});
      chk("wr_data", wd[w0+i], d);
      chk("wr_count", {21'd0, wl[w0+i]}, 32'(i + 1));
   endtask

   initial begin
      @(negedge clk1);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("rst_flags", {29'd0, mem_we, done, err}, 32'd0);
      chk("rst_addr_data", {22'd0, mem_addr} | mem_wdata, 32'd0);
      chk("rst_words", {21'd0, words_loaded}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk1);
      // two-word frame, no gaps
      w0 = nw;
      fr = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h00};
`ifdef MIPS_LOADER_CHECKSUM_EN
      fr.push_back(8'hA0);
`endif
      send_all();
      finish_frame();
      chk("a_nwrites", 32'(nw - w0), 32'd2);
      chk_write(0, 10'd0, 32'h20010005);
      chk_write(1, 10'd1, 32'h00221800);
      chk("a_words", {21'd0, words_loaded}, 32'd2);
      // bytes offered in DONE are refused
      in_valid = 1'b1;
      in_data = 8'h55;
      repeat (3) @(negedge clk1);
      chk("done_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      chk("done_nwrites", 32'(nw - w0), 32'd2);
      chk("done_stays", {31'd0, done}, 32'd1);
      pulse_start();
      chk("start_clears", {21'd0, words_loaded, done, err}, 32'd0);
      chk("start_ready", {30'd0, in_ready, cpu_hold}, 32'd3);
      // same frame with a 3-cycle gap mid-word
      w0 = nw;
      fr = '{8'h00, 8'h02, 8'h20, 8'h01};
      send_all();
      repeat (3) @(negedge clk1);
      fr = '{8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h00};
`ifdef MIPS_LOADER_CHECKSUM_EN
      fr.push_back(8'hA0);
`endif
      send_all();
      finish_frame();
      chk("gap_nwrites", 32'(nw - w0), 32'd2);
      chk_write(0, 10'd0, 32'h20010005);
      chk_write(1, 10'd1, 32'h00221800);
      pulse_start();
      // oversize header
      w0 = nw;
      fr = '{8'h04, 8'h01};
      send_all();
      chk("big_err", {31'd0, err}, 32'd1);
      chk("big_ready", {31'd0, in_ready}, 32'd0);
      chk("big_hold", {31'd0, cpu_hold}, 32'd1);
      @(negedge clk1);
      chk("big_nwrites", 32'(nw - w0), 32'd0);
      pulse_start();
      chk("err_cleared", {31'd0, err}, 32'd0);
      chk("err_rearm", {31'd0, in_ready}, 32'd1);
      // start mid-frame must be ignored
      fr = '{8'h00, 8'h01, 8'hDE, 8'hAD};
      send_all();
      pulse_start();
      fr = '{8'hBE, 8'hEF};
`ifdef MIPS_LOADER_CHECKSUM_EN
      fr.push_back(8'hC8);
`endif
      send_all();
      finish_frame();
      chk("d_nwrites", 32'(nw - w0), 32'd1);
      chk_write(0, 10'd0, 32'hDEADBEEF);
      pulse_start();
      // N = 1024 exactly fits
      fr = '{8'h04, 8'h00};
      send_all();
      chk("n1024_err", {31'd0, err}, 32'd0);
      chk("n1024_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk1);
      rst_n = 1'b1;
      @(negedge clk1);
      // reset mid-frame after 6 payload bytes
      w0 = nw;
      fr = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      send_all();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_words", {21'd0, words_loaded}, 32'd0);
      chk("arst_state", {28'd0, in_ready, cpu_hold, done, err}, 32'hC);
      chk("arst_mem", {30'd0, mem_we, |mem_addr}, 32'd0);
      @(negedge clk1);
      rst_n = 1'b1;
      chk("arst_nwrites", 32'(nw - w0), 32'd1);
      chk_write(0, 10'd0, 32'h11223344);
      @(negedge clk1);
      w0 = nw;
      fr = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef MIPS_LOADER_CHECKSUM_EN
      fr.push_back(8'hF2);
`endif
      send_all();
      finish_frame();
      chk("reload_nwrites", 32'(nw - w0), 32'd1);
      chk_write(0, 10'd0, 32'hAABBCCDD);
      pulse_start();
      // empty image
      w0 = nw;
      fr = '{8'h00, 8'h00};
`ifdef MIPS_LOADER_CHECKSUM_EN
      fr.push_back(8'h00);
`endif
      send_all();
      finish_frame();
      chk("empty_nwrites", 32'(nw - w0), 32'd0);
      chk("empty_words", {21'd0, words_loaded}, 32'd0);
      in_valid = 1'b1;
      @(negedge clk1);
      chk("empty_done_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
      pulse_start();
      w0 = nw;
      fr = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
      send_all();
      finish_frame();
      chk_write(0, 10'd0, 32'h01020304);
      pulse_start();
      w0 = nw;
      fr = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
      send_all();
      @(negedge clk1);
      chk("ck_err", {31'd0, err}, 32'd1);
      chk("ck_hold", {31'd0, cpu_hold}, 32'd1);
      chk("ck_done", {31'd0, done}, 32'd0);
      chk("ck_nwrites", 32'(nw - w0), 32'd1);
      chk_write(0, 10'd0, 32'h01020304);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
